key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 16 +
 rtl/key_sync.sv | 28 ++
 rtl/key_debounce.sv | 128 ++++++++++++
 tb/tb_key_debounce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button blocks: the debounce FSM state encoding
// and the default timing constants for a 24 MHz system clock.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_fsm_e;

    // 10 ms stable time and 1 s long-press time at 24 MHz
    localparam int unsigned DB_CYCLES_DEFAULT   = 240000;
    localparam int unsigned LONG_CYCLES_DEFAULT = 24000000;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset level
// so that both active-low and active-high buttons idle correctly out of reset.
module key_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments are what make these two flops a real shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizes an active-low key, filters bounce in both
// directions and emits registered press, release and long-hold strobes.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input  logic sclk,
    input  logic rst,
    input  logic key_n,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_param_check
        $error("key_debounce: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
    end

    // long_cnt must be able to hold LONG_CYCLES itself, where it saturates
    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic key_sync_w;

    key_fsm_e          state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              key_state_q, key_state_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    key_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (sclk),
        .rst (rst),
        .d_i (key_n),
        .q_o (key_sync_w)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            long_cnt_q  <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            long_cnt_q  <= long_cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets its default first, so no path leaves one unassigned (no latch).
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        long_cnt_d  = long_cnt_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        // Hold time keeps running through a release bounce; saturation stops a re-fire
        if (state_q == HELD || state_q == RELEASE_DB) begin
            if (long_cnt_q < LONG_MAX) long_cnt_d = long_cnt_q + LONG_W'(1);
            if (long_cnt_q == LONG_LAST) long_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!key_sync_w) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            PRESS_DB: begin
                if (key_sync_w) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    key_state_d = 1'b1;
                    press_d     = 1'b1;
                    long_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (key_sync_w) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end
            end
            RELEASE_DB: begin
                if (!key_sync_w) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    key_state_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_state     = key_state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts strobes
// and the debounced level per clock edge; a monitor compares them at each falling edge.
module tb_key_debounce;

    localparam int DB   = 4;
    localparam int LONG = 20;

    logic sclk;
    logic rst;
    logic key_n;
    logic key_state;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    key_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .sclk          (sclk),
        .rst           (rst),
        .key_n         (key_n),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    typedef struct {
        int         edge_no;
        logic [2:0] mask;      // {long, release, press}
    } ev_t;

    typedef struct {
        int   edge_no;
        logic lvl;
    } lvl_t;

    ev_t  ev_q[$];
    lvl_t lvl_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   edge_cnt = 0;

    // Reference model: key_n is seen two edges late; the level flips after DB+1
    // consecutive seen samples at the opposite level; long fires LONG edges after press.
    logic hist[$];
    logic m_pressed;
    int   m_run;
    int   m_press_edge;

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(posedge sclk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b1);
        hist.push_back(1'b1);
        m_pressed    = 1'b0;
        m_run        = 0;
        m_press_edge = 0;
    endtask

    task automatic model_step(input logic v);
        int         e;
        logic       seen;
        logic [2:0] mask;
        e    = edge_cnt + 1;
        seen = hist.pop_front();
        hist.push_back(v);
        mask = 3'b000;
        if (m_pressed && (e - m_press_edge == LONG)) mask[2] = 1'b1;
        // a released key needs lows (0) to press; a pressed key needs highs (1) to release
        if (seen == m_pressed) m_run++;
        else m_run = 0;
        if (m_run == DB + 1) begin
            m_run     = 0;
            m_pressed = !m_pressed;
            if (m_pressed) begin
                mask[0]      = 1'b1;
                m_press_edge = e;
            end else begin
                mask[1] = 1'b1;
            end
        end
        lvl_q.push_back('{e, m_pressed});
        if (mask != 3'b000) ev_q.push_back('{e, mask});
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sclk);
            key_n = v;
            model_step(v);
        end
    endtask

    task automatic pulse_reset();
        @(negedge sclk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_key_state", int'(key_state), 0);
        check("rst_async_press", int'(press_pulse), 0);
        check("rst_async_release", int'(release_pulse), 0);
        check("rst_async_long", int'(long_pulse), 0);
        repeat (3) @(posedge sclk);
        #1;
        check("rst_hold_outputs", int'({key_state, press_pulse, release_pulse, long_pulse}), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: level every edge; strobes popped whenever the DUT shows one
    initial begin
        ev_t  ev;
        lvl_t lv;
        logic [2:0] got;
        forever begin
            @(negedge sclk);
            if (lvl_q.size() > 0 && lvl_q[0].edge_no == edge_cnt) begin
                lv = lvl_q.pop_front();
                check("key_state", int'(key_state), int'(lv.lvl));
            end
            while (ev_q.size() > 0 && ev_q[0].edge_no < edge_cnt) begin
                ev = ev_q.pop_front();
                check("strobe_missed", 0, int'(ev.mask));
            end
            got = {long_pulse, release_pulse, press_pulse};
            if (got != 3'b000) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_strobe", int'(got), 0);
                end else begin
                    ev = ev_q.pop_front();
                    check("strobe_edge", edge_cnt, ev.edge_no);
                    check("strobe_kind", int'(got), int'(ev.mask));
                end
            end
        end
    end

    initial begin
        rst   = 1'b0;
        key_n = 1'b1;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset_key_state", int'(key_state), 0);
        check("reset_strobes", int'({press_pulse, release_pulse, long_pulse}), 0);
        repeat (2) @(posedge sclk);
        #1;
        check("reset_hold_outputs", int'({key_state, press_pulse, release_pulse, long_pulse}), 0);
        rst = 1'b0;
        model_reset();

        drive(1'b1, 8);
        // clean press and release
        drive(1'b0, 12);
        drive(1'b1, 12);
        // press bounce
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 12);
        drive(1'b1, 10);
        // long press
        drive(1'b0, 40);
        drive(1'b1, 10);
        // release bounce while held
        drive(1'b0, 10);
        drive(1'b1, 2);
        drive(1'b0, 10);
        drive(1'b1, 10);
        // reset while held, key still down
        drive(1'b0, 10);
        pulse_reset();
        drive(1'b0, 10);
        drive(1'b1, 10);
        // release acceptance on the long-count edge
        drive(1'b0, LONG);
        drive(1'b1, 10);
        // random segments, short ones acting as bounce
        for (int s = 0; s < 40; s++) begin
            drive(logic'(s % 2 == 0 ? 0 : 1), int'($urandom_range(1, 30)));
        end
        drive(1'b1, 15);

        repeat (3) @(negedge sclk);
        #1;
        check("pending_strobes", ev_q.size(), 0);
        check("pending_levels", lvl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
